// File: rtl/log_arbiter.sv
// -----------------------------------------------------------------------------
// log_arbiter
//   Three-source round-robin log arbiter feeding a byte-wide UART transmitter.
//   A granted source's payload is latched, acknowledged with a one-cycle pulse,
//   and sent as a frame: one header byte (HEADER_BASE | id) followed by the
//   payload bytes, most significant byte first, under valid/ready handshaking.
//
// Ports
//   i_clock    : system clock, rising edge
//   i_reset    : synchronous active-high reset
//   i_enable   : permits new grants (sampled only while idle)
//   i_req[2:0] : per-source log request (level)
//   i_data     : per-source payload, source k at [k*DATA_SIZE +: DATA_SIZE]
//   o_ack[2:0] : one-cycle pulse, payload of that source captured
//   o_txData   : byte to transmit
//   o_txValid  : o_txData valid
//   i_txReady  : transmitter accepts the byte this cycle
//   o_busy     : a frame is being granted or sent
// -----------------------------------------------------------------------------
module log_arbiter #(
    parameter int         DATA_SIZE      = 16,
    parameter int         UART_DATA_SIZE = 8,
    parameter logic [7:0] HEADER_BASE    = 8'hA0
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic [2:0]                  i_req,
    input  logic [3*DATA_SIZE-1:0]      i_data,
    output logic [2:0]                  o_ack,
    output logic [UART_DATA_SIZE-1:0]   o_txData,
    output logic                        o_txValid,
    input  logic                        i_txReady,
    output logic                        o_busy
);

    localparam int NBYTES = DATA_SIZE / UART_DATA_SIZE;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        SEND_HDR  = 2'd2,
        SEND_DATA = 2'd3
    } state_t;

    state_t                 state;
    logic [1:0]             grant_id;
    logic [1:0]             last_grant;
    logic [1:0]             pick;
    logic [DATA_SIZE-1:0]   payload;
    logic [CNT_W-1:0]       byte_cnt;

    // Round-robin pick: search starts at the source after the last grant.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        case (last)
            2'd0: begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1: begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (req[first]) begin
            rr_pick = first;
        end else if (req[second]) begin
            rr_pick = second;
        end else begin
            rr_pick = third;
        end
    endfunction

    // Combinational selection of the next source to grant.
    always_comb begin
        pick = rr_pick(last_grant, i_req);
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            o_ack      <= 3'b000;
            o_txValid  <= 1'b0;
            o_txData   <= '0;
            o_busy     <= 1'b0;
            last_grant <= 2'd2;
            byte_cnt   <= '0;
            grant_id   <= 2'd0;
            payload    <= '0;
        end else begin
            o_ack <= 3'b000;
            case (state)
                IDLE: begin
                    if (i_enable && (i_req != 3'b000)) begin
                        grant_id <= pick;
                        o_ack    <= 3'b001 << pick;
                        o_busy   <= 1'b1;
                        state    <= GRANT;
                    end else begin
                        o_busy   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                GRANT: begin
                    // Payload is frozen here so later i_data changes cannot
                    // corrupt the frame in flight.
                    payload    <= i_data[grant_id*DATA_SIZE +: DATA_SIZE];
                    last_grant <= grant_id;
                    o_txData   <= UART_DATA_SIZE'(HEADER_BASE | {6'b000000, grant_id});
                    o_txValid  <= 1'b1;
                    byte_cnt   <= '0;
                    state      <= SEND_HDR;
                end
                SEND_HDR: begin
                    if (i_txReady) begin
                        o_txData <= payload[DATA_SIZE-1 -: UART_DATA_SIZE];
                        payload  <= payload << UART_DATA_SIZE;
                        byte_cnt <= '0;
                        state    <= SEND_DATA;
                    end else begin
                        state    <= SEND_HDR;
                    end
                end
                SEND_DATA: begin
                    if (i_txReady) begin
                        if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                            o_txValid <= 1'b0;
                            o_txData  <= '0;
                            o_busy    <= 1'b0;
                            byte_cnt  <= '0;
                            state     <= IDLE;
                        end else begin
                            o_txData  <= payload[DATA_SIZE-1 -: UART_DATA_SIZE];
                            payload   <= payload << UART_DATA_SIZE;
                            byte_cnt  <= byte_cnt + CNT_W'(1);
                            state     <= SEND_DATA;
                        end
                    end else begin
                        state <= SEND_DATA;
                    end
                end
                default: begin
                    o_txValid <= 1'b0;
                    o_txData  <= '0;
                    o_busy    <= 1'b0;
                    byte_cnt  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/log_arbiter.md
LOG_ARBITER -- requirements
Module: log_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, the payload width per source; it must be a multiple of UART_DATA_SIZE.
REQ-002 SHALL have parameter UART_DATA_SIZE, default 8, the byte width presented to the UART transmitter.
REQ-003 SHALL have parameter HEADER_BASE, default 8'hA0, the header byte base value; the source id is ORed into bits [1:0].
REQ-004 SHALL have i_clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have i_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have i_enable, input, 1, which permits new grants when high.
REQ-007 SHALL have i_req, input, 3, the per-source log request; bit k belongs to source k.
REQ-008 SHALL have i_data, input, 3*DATA_SIZE, the per-source payload; source k occupies bits [k*DATA_SIZE +: DATA_SIZE].
REQ-009 SHALL have o_ack, output, 3, a one-cycle per-source pulse meaning payload captured.
REQ-010 SHALL have o_txData, output, UART_DATA_SIZE, the byte to transmit.
REQ-011 SHALL have o_txValid, output, 1, meaning o_txData is valid.
REQ-012 SHALL have i_txReady, input, 1, meaning the transmitter accepts a byte; a byte transfers on a cycle where o_txValid and i_txReady are both high.
REQ-013 SHALL have o_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, GRANT, SEND_HDR, SEND_DATA.
REQ-015 SHALL, in IDLE with i_enable high and i_req nonzero, select one requesting source by round-robin and go to GRANT on the next cycle.
REQ-016 SHALL start the round-robin search at (last_grant+1) mod 3, wrapping 2->0; last_grant resets to 2, so source 0 has first priority after reset.
REQ-017 SHALL, in GRANT (one cycle), latch the selected source's payload and id, pulse o_ack[id] for exactly that cycle, update last_grant, and go to SEND_HDR.
REQ-018 SHALL, in SEND_HDR, drive o_txValid=1 and o_txData=HEADER_BASE|id, and go to SEND_DATA on transfer.
REQ-019 SHALL, in SEND_DATA, emit DATA_SIZE/UART_DATA_SIZE payload bytes, most significant byte first, advancing the byte counter only on transfer.
REQ-020 SHALL, after the last payload byte transfers, go to IDLE with o_txValid=0 on the next cycle.
REQ-021 SHALL hold o_txData stable while o_txValid is high and i_txReady is low; o_txValid SHALL never drop without a transfer.
REQ-022 SHALL latch the payload in GRANT; later changes on i_data or i_req SHALL NOT alter a frame in flight.
REQ-023 SHALL evaluate i_enable only in IDLE; deasserting it mid-frame lets the frame complete, and no new grant occurs until it is reasserted.
REQ-024 SHALL not queue requests: i_req is level-sampled, and a requester keeps i_req high until it sees its o_ack.
REQ-025 SHALL give a minimum frame latency, from the IDLE sample of i_req to the final transfer with i_txReady held high, of 1 + 1 + (1 + DATA_SIZE/UART_DATA_SIZE) cycles: 5 cycles at the defaults.
REQ-026 SHALL, with all three sources continuously requesting, grant in the order 0,1,2,0,...; no source waits more than two frames.

Reset
REQ-027 SHALL, on i_reset high at a clock edge, set the state to IDLE, o_ack=0, o_txValid=0, o_txData=0, o_busy=0, last_grant=2 and the byte counter to 0, regardless of the current state.
REQ-028 SHALL drop any frame in progress when reset is asserted mid-frame, with no further bytes and no ack until a new grant.
REQ-029 SHALL let reset take priority over every other input on the same edge.

Verification
REQ-030 Single request: i_req=3'b010, data1=16'h1234, i_txReady=1 -> o_ack=3'b010 for one cycle; bytes A1, 12, 34; o_busy low after the last byte.
REQ-031 Backpressure: same stimulus with i_txReady low for 4 cycles during each byte -> o_txData held constant, bytes and order unchanged, no duplicates.
REQ-032 Round-robin: i_req=3'b111 held for 6 frames -> header sequence A0, A1, A2, A0, A1, A2.
REQ-033 Payload change: data0 changed from 16'hBEEF to 16'h0000 right after the ack -> frame A0, BE, EF.
REQ-034 Enable: i_enable dropped during SEND_DATA -> the frame completes; with i_req=3'b001 still high, no grant while disabled; grant occurs one cycle after i_enable returns high.
REQ-035 Reset: i_reset for one cycle during SEND_DATA -> next cycle o_txValid=0 and o_busy=0; a following i_req=3'b111 grants source 0 first.
